// File: rtl/image_write_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : image_write_pkg
//  Description : Shared constants for the image_write stream-to-memory writer.
//                Config register addresses on the shared cfg bus (placed so
//                they stay clear of the image_read CFG_IR_* range) and the
//                controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package image_write_pkg;

    // cfg bus register map
    localparam int unsigned CFG_IW_BASE   = 8;   // start address
    localparam int unsigned CFG_IW_IMG_W  = 9;   // [15:0]  width-1
    localparam int unsigned CFG_IW_IMG_DH = 10;  // {depth_groups-1, height-1}
    localparam int unsigned CFG_IW_STRIDE = 11;  // {plane_stride, row_stride}

    // Controller state encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_ACTIVE = 1'b1;

endpackage : image_write_pkg
`default_nettype wire

// File: rtl/image_write_addr.sv
`default_nettype none
// ============================================================================
//  Module      : image_write_addr
//  Description : Frame address generator. Walks width/height/depth counters
//                and keeps row/plane start addresses as running sums of the
//                strides, so no multiplier is needed.
//  Ports       : start_i  - load counters and accumulators from base_i
//                adv_i    - one beat accepted; step to the next position
//                *_m1_i   - frame dimensions minus one
//                addr_o   - address of the current position
//                final_o  - current position is the last of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module image_write_addr #(
    parameter int MEM_AWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  adv_i,
    input  logic [MEM_AWIDTH-1:0] base_i,
    input  logic [15:0]           w_m1_i,
    input  logic [15:0]           h_m1_i,
    input  logic [15:0]           d_m1_i,
    input  logic [MEM_AWIDTH-1:0] row_stride_i,
    input  logic [MEM_AWIDTH-1:0] plane_stride_i,
    output logic [MEM_AWIDTH-1:0] addr_o,
    output logic                  final_o
);

    logic [15:0]           w_cnt_q, w_cnt_d;
    logic [15:0]           h_cnt_q, h_cnt_d;
    logic [15:0]           d_cnt_q, d_cnt_d;
    logic [MEM_AWIDTH-1:0] row_addr_q, row_addr_d;
    logic [MEM_AWIDTH-1:0] plane_addr_q, plane_addr_d;
    logic [MEM_AWIDTH-1:0] plane_next;
    logic                  w_last, h_last, d_last;

    assign w_last     = (w_cnt_q == w_m1_i);
    assign h_last     = (h_cnt_q == h_m1_i);
    assign d_last     = (d_cnt_q == d_m1_i);
    assign plane_next = plane_addr_q + plane_stride_i;

    assign final_o = w_last & h_last & d_last;
    // Modulo-2^MEM_AWIDTH sum; wrap-around is intentional
    assign addr_o  = row_addr_q + MEM_AWIDTH'(w_cnt_q);

    always_comb begin
        w_cnt_d      = w_cnt_q;
        h_cnt_d      = h_cnt_q;
        d_cnt_d      = d_cnt_q;
        row_addr_d   = row_addr_q;
        plane_addr_d = plane_addr_q;
        if (start_i) begin
            w_cnt_d      = '0;
            h_cnt_d      = '0;
            d_cnt_d      = '0;
            row_addr_d   = base_i;
            plane_addr_d = base_i;
        end else if (adv_i) begin
            if (!w_last) begin
                w_cnt_d = w_cnt_q + 16'd1;
            end else begin
                w_cnt_d = '0;
                if (!h_last) begin
                    h_cnt_d    = h_cnt_q + 16'd1;
                    row_addr_d = row_addr_q + row_stride_i;
                end else begin
                    // Next plane: the row pointer restarts at the new plane
                    h_cnt_d      = '0;
                    d_cnt_d      = d_last ? 16'd0 : d_cnt_q + 16'd1;
                    plane_addr_d = plane_next;
                    row_addr_d   = plane_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_cnt_q      <= '0;
            h_cnt_q      <= '0;
            d_cnt_q      <= '0;
            row_addr_q   <= '0;
            plane_addr_q <= '0;
        end else begin
            w_cnt_q      <= w_cnt_d;
            h_cnt_q      <= h_cnt_d;
            d_cnt_q      <= d_cnt_d;
            row_addr_q   <= row_addr_d;
            plane_addr_q <= plane_addr_d;
        end
    end

endmodule : image_write_addr
`default_nettype wire

// File: rtl/image_write.sv
`default_nettype none
// ============================================================================
//  Module      : image_write
//  Description : Ready/valid pixel-group stream to image-buffer writer.
//                Configured over the cfg bus while idle, started by `next`,
//                writes one group per accepted beat at base + strided offset.
//  Ports       : cfg_*      - config register write bus
//                next       - start-of-frame pulse (ignored while active)
//                image_*    - input stream (bus/last/val/rdy)
//                wr_*       - memory write port (one cycle after acceptance)
//                done       - pulses with the final write
//                error      - sticky frame-length mismatch flag
//  Revision    : 1.0 - initial release
// ============================================================================
module image_write
    import image_write_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int GROUP_NB   = 4,
    parameter int IMG_WIDTH  = 16,
    parameter int MEM_AWIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic                          next,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
    input  logic                          image_last,
    input  logic                          image_val,
    output logic                          image_rdy,
    output logic                          wr_val,
    output logic [MEM_AWIDTH-1:0]         wr_addr,
    output logic [GROUP_NB*IMG_WIDTH-1:0] wr_data,
    output logic                          done,
    output logic                          error
);

    localparam int DW = GROUP_NB * IMG_WIDTH;

    state_t                state_q, state_d;
    logic                  start, accept, rdy;
    logic [MEM_AWIDTH-1:0] base_q;
    logic [15:0]           w_m1_q, h_m1_q, d_m1_q, rs_q, ps_q;
    logic [MEM_AWIDTH-1:0] addr;
    logic                  is_final;
    logic                  wr_val_q, done_q, error_q, error_d;
    logic [MEM_AWIDTH-1:0] wr_addr_q;
    logic [DW-1:0]         wr_data_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (next)               state_d = ST_ACTIVE;
            ST_ACTIVE: if (accept && is_final) state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Ready is a pure decode of the state register, so it rises the cycle
    // after `next` is sampled and drops the cycle after the final beat.
    always_comb begin
        rdy    = (state_q == ST_ACTIVE);
        start  = (state_q == ST_IDLE) && next;
        accept = rdy && image_val;
    end

    // ---------------- Config registers (idle only) ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q <= '0;
            w_m1_q <= '0;
            h_m1_q <= '0;
            d_m1_q <= '0;
            rs_q   <= '0;
            ps_q   <= '0;
        end else if (cfg_valid && state_q == ST_IDLE) begin
            if (cfg_addr == CFG_AWIDTH'(CFG_IW_BASE))
                base_q <= cfg_data[MEM_AWIDTH-1:0];
            if (cfg_addr == CFG_AWIDTH'(CFG_IW_IMG_W))
                w_m1_q <= cfg_data[15:0];
            if (cfg_addr == CFG_AWIDTH'(CFG_IW_IMG_DH)) begin
                h_m1_q <= cfg_data[15:0];
                d_m1_q <= cfg_data[31:16];
            end
            if (cfg_addr == CFG_AWIDTH'(CFG_IW_STRIDE)) begin
                rs_q <= cfg_data[15:0];
                ps_q <= cfg_data[31:16];
            end
        end
    end

    image_write_addr #(
        .MEM_AWIDTH (MEM_AWIDTH)
    ) u_addr (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .adv_i          (accept),
        .base_i         (base_q),
        .w_m1_i         (w_m1_q),
        .h_m1_i         (h_m1_q),
        .d_m1_i         (d_m1_q),
        .row_stride_i   (MEM_AWIDTH'(rs_q)),
        .plane_stride_i (MEM_AWIDTH'(ps_q)),
        .addr_o         (addr),
        .final_o        (is_final)
    );

    // Length check: image_last must coincide exactly with the counter-defined
    // final beat; any disagreement latches error until the next start.
    always_comb begin
        error_d = error_q;
        if (start)
            error_d = 1'b0;
        else if (accept && (image_last != is_final))
            error_d = 1'b1;
    end

    // ---------------- Write port ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_val_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            wr_val_q <= accept;
            done_q   <= accept && is_final;
            error_q  <= error_d;
            if (accept) begin
                wr_addr_q <= addr;
                wr_data_q <= image_bus;
            end
        end
    end

    assign image_rdy = rdy;
    assign wr_val    = wr_val_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule : image_write
`default_nettype wire

// File: tb/tb_image_write.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_write
//  Description : Directed self-checking bench for image_write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_write;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   cfg_data;
    logic [4:0]    cfg_addr;
    logic          cfg_valid;
    logic          next;
    logic [DW-1:0] image_bus;
    logic          image_last;
    logic          image_val;
    logic          image_rdy;
    logic          wr_val;
    logic [15:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic          done;
    logic          error;

    int n_cmp = 0;
    int n_mis = 0;

    image_write #(
        .CFG_DWIDTH (32),
        .CFG_AWIDTH (5),
        .GROUP_NB   (4),
        .IMG_WIDTH  (16),
        .MEM_AWIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_data   (cfg_data),
        .cfg_addr   (cfg_addr),
        .cfg_valid  (cfg_valid),
        .next       (next),
        .image_bus  (image_bus),
        .image_last (image_last),
        .image_val  (image_val),
        .image_rdy  (image_rdy),
        .wr_val     (wr_val),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int i);
        logic [15:0] a, b, c, d;
        a = 16'(i);
        b = 16'(i) ^ 16'h5A5A;
        c = 16'hC000 + 16'(i);
        d = 16'hFFFF - 16'(i);
        return {a, b, c, d};
    endfunction

    // Reference address: direct base + d*ps + h*rs + w, modulo 2^16
    function automatic logic [15:0] exp_addr(input int i, input int base, input int w,
                                             input int h, input int rs, input int ps);
        int wi, hi, di;
        wi = i % w;
        hi = (i / w) % h;
        di = i / (w * h);
        return 16'(base + di * ps + hi * rs + wi);
    endfunction

    task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
        cfg_addr  = a;
        cfg_data  = d;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic start_frame();
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        chk("start_rdy", DW'(image_rdy), DW'(1'b1));
        chk("start_err_clr", DW'(error), DW'(1'b0));
    endtask

    // Streams w*h*d beats; last_at is the 0-based beat carrying image_last,
    // gap inserts an idle cycle after each beat, poke tries a cfg write and
    // a `next` mid-frame.
    task automatic run_frame(input int base, input int w, input int h, input int d,
                             input int rs, input int ps, input int last_at,
                             input bit gap, input bit poke);
        int  n;
        bit  err_exp;
        n = w * h * d;
        err_exp = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("rdy_b%0d", i), DW'(image_rdy), DW'(1'b1));
            image_val  = 1'b1;
            image_bus  = beat_data(i);
            image_last = (i == last_at);
            if (poke && i == 5) begin
                cfg_addr  = 5'd8;
                cfg_data  = 32'h0000_0200;
                cfg_valid = 1'b1;
                next      = 1'b1;
            end
            @(negedge clk);
            image_val  = 1'b0;
            image_last = 1'b0;
            cfg_valid  = 1'b0;
            next       = 1'b0;
            if (i == last_at && i != n - 1) err_exp = 1'b1;
            if (i == n - 1 && last_at != n - 1) err_exp = 1'b1;
            chk($sformatf("wr_val_b%0d", i), DW'(wr_val), DW'(1'b1));
            chk($sformatf("wr_addr_b%0d", i), DW'(wr_addr), DW'(exp_addr(i, base, w, h, rs, ps)));
            chk($sformatf("wr_data_b%0d", i), wr_data, beat_data(i));
            chk($sformatf("done_b%0d", i), DW'(done), DW'(i == n - 1));
            chk($sformatf("error_b%0d", i), DW'(error), DW'(err_exp));
            if (gap) begin
                @(negedge clk);
                chk($sformatf("gap_wr_val_b%0d", i), DW'(wr_val), DW'(1'b0));
                chk($sformatf("gap_done_b%0d", i), DW'(done), DW'(1'b0));
            end
        end
        chk("end_rdy", DW'(image_rdy), DW'(1'b0));
        @(negedge clk);
        chk("end_wr_val", DW'(wr_val), DW'(1'b0));
        chk("end_done", DW'(done), DW'(1'b0));
        chk("end_error", DW'(error), DW'(err_exp));
    endtask

    initial begin
        rst        = 1'b0;
        cfg_data   = '0;
        cfg_addr   = '0;
        cfg_valid  = 1'b0;
        next       = 1'b0;
        image_bus  = '0;
        image_last = 1'b0;
        image_val  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst0_rdy", DW'(image_rdy), '0);
        chk("rst0_wr_val", DW'(wr_val), '0);
        chk("rst0_wr_addr", DW'(wr_addr), '0);
        chk("rst0_wr_data", wr_data, '0);
        chk("rst0_done", DW'(done), '0);
        chk("rst0_error", DW'(error), '0);
        rst = 1'b1;
        @(negedge clk);

        // Basic frame: BASE=0x100, W=4, H=2, D=2, rs=8, ps=32
        cfg_wr(5'd8,  32'h0000_0100);
        cfg_wr(5'd9,  32'd3);
        cfg_wr(5'd10, {16'd1, 16'd1});
        cfg_wr(5'd11, {16'd32, 16'd8});
        cfg_wr(5'd3,  32'hDEAD_BEEF);   // unknown address, ignored
        start_frame();
        run_frame(32'h100, 4, 2, 2, 8, 32, 15, 1'b0, 1'b0);
        // Spot-check the last write's address by hand: 0x100+32+8+3
        chk("hand_last_addr", DW'(wr_addr), DW'(16'h012B));

        // Same frame with idle cycles between beats
        start_frame();
        run_frame(32'h100, 4, 2, 2, 8, 32, 15, 1'b1, 1'b0);

        // Early image_last on beat 5
        start_frame();
        run_frame(32'h100, 4, 2, 2, 8, 32, 4, 1'b0, 1'b0);

        // Error clears on start; cfg write and `next` mid-frame are ignored
        start_frame();
        run_frame(32'h100, 4, 2, 2, 8, 32, 15, 1'b0, 1'b1);

        // Address wrap-around
        cfg_wr(5'd8,  32'h0000_FFFE);
        cfg_wr(5'd10, 32'd0);
        start_frame();
        run_frame(32'hFFFE, 4, 1, 1, 8, 32, 3, 1'b0, 1'b0);
        chk("hand_wrap_addr", DW'(wr_addr), DW'(16'h0001));

        // Asynchronous reset mid-frame
        start_frame();
        image_val  = 1'b1;
        image_bus  = beat_data(7);
        image_last = 1'b1;
        @(negedge clk);
        image_val  = 1'b0;
        image_last = 1'b0;
        chk("pre_rst_wr_val", DW'(wr_val), DW'(1'b1));
        chk("pre_rst_error", DW'(error), DW'(1'b1));
        #2 rst = 1'b0;
        #1;
        chk("arst_rdy", DW'(image_rdy), '0);
        chk("arst_wr_val", DW'(wr_val), '0);
        chk("arst_wr_addr", DW'(wr_addr), '0);
        chk("arst_wr_data", wr_data, '0);
        chk("arst_done", DW'(done), '0);
        chk("arst_error", DW'(error), '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", DW'(image_rdy), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_image_write
`default_nettype wire
